// File: rtl/ddr_scan_arbiter.sv
// Two-master Avalon-MM arbiter: scanout reader (read priority, credit-limited)
// and pixel writer (bursts, anti-starvation) sharing one DDR3 slave port.
module ddr_scan_arbiter #(
   parameter int ADDR_W       = 29,
   parameter int DATA_W       = 128,
   parameter int BURST_W      = 7,
   parameter int MAX_PENDING  = 256,
   parameter int STARVE_LIMIT = 64
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic [BURST_W-1:0]  m0_burstcount,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [BURST_W-1:0]  m1_burstcount,
   output logic                m1_waitrequest,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   output logic [BURST_W-1:0]  avm_burstcount,
   input  logic                avm_waitrequest,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_readdatavalid,
   output logic                err_underflow
);

   localparam int PEND_W = $clog2(MAX_PENDING + 1);
   localparam int STRV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR} state_t;

   state_t             state, state_nxt;
   logic [PEND_W-1:0]  pending, pending_nxt;
   logic [STRV_W-1:0]  starve, starve_nxt;
   logic [BURST_W-1:0] beats_left, beats_left_nxt;
   logic [31:0]        credit_sum;
   logic               credit_ok, starve_full;
   logic               rd_acc, wr_acc, underflow;
   logic [PEND_W-1:0]  add_v, sub_v;

   assign m0_readdata      = avm_readdata;
   assign m0_readdatavalid = avm_readdatavalid;

   assign credit_sum  = 32'(pending) + 32'(m0_burstcount);
   assign credit_ok   = credit_sum <= 32'(MAX_PENDING);
   assign starve_full = starve == STRV_W'(STARVE_LIMIT);

   assign rd_acc = (state == GRANT_RD) && m0_read && !avm_waitrequest;
   assign wr_acc = (state == GRANT_WR) && m1_write && !avm_waitrequest;

   always_comb begin
      state_nxt      = state;
      beats_left_nxt = beats_left;
      avm_address    = '0;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_writedata  = '0;
      avm_byteenable = '0;
      avm_burstcount = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      unique case (state)
         IDLE: begin
            if (starve_full && m1_write)
               state_nxt = GRANT_WR;
            else if (m0_read && credit_ok)
               state_nxt = GRANT_RD;
            else if (m1_write)
               state_nxt = GRANT_WR;
         end
         GRANT_RD: begin
            avm_address    = m0_address;
            avm_read       = m0_read;
            avm_burstcount = m0_burstcount;
            m0_waitrequest = avm_waitrequest;
            if (rd_acc)
               state_nxt = IDLE;
         end
         GRANT_WR: begin
            avm_address    = m1_address;
            avm_write      = m1_write;
            avm_writedata  = m1_writedata;
            avm_byteenable = m1_byteenable;
            avm_burstcount = m1_burstcount;
            m1_waitrequest = avm_waitrequest;
            // beats_left==0 inside the grant means the first beat is still due
            if (wr_acc) begin
               if (beats_left == '0) begin
                  if (m1_burstcount <= BURST_W'(1))
                     state_nxt = IDLE;
                  else
                     beats_left_nxt = m1_burstcount - BURST_W'(1);
               end else begin
                  beats_left_nxt = beats_left - BURST_W'(1);
                  if (beats_left == BURST_W'(1))
                     state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // a beat arriving with the accepting command is charged to that command
   always_comb begin
      underflow = avm_readdatavalid && (pending == '0) && !rd_acc;
      add_v     = rd_acc ? PEND_W'(m0_burstcount) : '0;
      sub_v     = (avm_readdatavalid && !underflow) ? PEND_W'(1) : '0;
      pending_nxt = pending + add_v - sub_v;
   end

   always_comb begin
      starve_nxt = starve;
      if (state != GRANT_WR && state_nxt == GRANT_WR)
         starve_nxt = '0;
      else if (m1_write && state != GRANT_WR && !starve_full)
         starve_nxt = starve + STRV_W'(1);
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state         <= IDLE;
         pending       <= '0;
         starve        <= '0;
         beats_left    <= '0;
         err_underflow <= 1'b0;
      end else begin
         state      <= state_nxt;
         pending    <= pending_nxt;
         starve     <= starve_nxt;
         beats_left <= beats_left_nxt;
         if (underflow)
            err_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ddr_scan_arbiter.sv
// Directed bench for ddr_scan_arbiter: read credit, starvation, write bursts,
// underflow and asynchronous reset.
module tb_ddr_scan_arbiter;

   localparam int ADDR_W = 29;
   localparam int DATA_W = 128;
   localparam int BURST_W = 7;

   logic                clk_clk;
   logic                reset_reset_n;
   logic [ADDR_W-1:0]   m0_address;
   logic                m0_read;
   logic [BURST_W-1:0]  m0_burstcount;
   logic                m0_waitrequest;
   logic [DATA_W-1:0]   m0_readdata;
   logic                m0_readdatavalid;
   logic [ADDR_W-1:0]   m1_address;
   logic                m1_write;
   logic [DATA_W-1:0]   m1_writedata;
   logic [DATA_W/8-1:0] m1_byteenable;
   logic [BURST_W-1:0]  m1_burstcount;
   logic                m1_waitrequest;
   logic [ADDR_W-1:0]   avm_address;
   logic                avm_read;
   logic                avm_write;
   logic [DATA_W-1:0]   avm_writedata;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic [BURST_W-1:0]  avm_burstcount;
   logic                avm_waitrequest;
   logic [DATA_W-1:0]   avm_readdata;
   logic                avm_readdatavalid;
   logic                err_underflow;

   int total = 0;
   int bad = 0;
   int beats;

   ddr_scan_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
      .MAX_PENDING(32), .STARVE_LIMIT(4)
   ) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .m0_address(m0_address), .m0_read(m0_read),
      .m0_burstcount(m0_burstcount), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_burstcount(m1_burstcount), .m1_waitrequest(m1_waitrequest),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid), .err_underflow(err_underflow)
   );

   initial begin
      clk_clk = 1'b0;
      forever #5 clk_clk = ~clk_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic rd_cmd(input int bc);
      logic got;
      got = 1'b0;
      m0_read = 1'b1;
      m0_burstcount = 7'(bc);
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (!m0_waitrequest && avm_read) got = 1'b1;
         else @(negedge clk_clk);
      end
      @(negedge clk_clk);
      m0_read = 1'b0;
      chk("rd_grant", got, 1);
   endtask

   initial begin
      reset_reset_n = 1'b0;
      m0_address = '0; m0_read = 1'b0; m0_burstcount = 7'd1;
      m1_address = '0; m1_write = 1'b0; m1_writedata = '0;
      m1_byteenable = '1; m1_burstcount = 7'd1;
      avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
      #1;
      chk("rst_m0_wait", m0_waitrequest, 1);
      chk("rst_m1_wait", m1_waitrequest, 1);
      chk("rst_avm_read", avm_read, 0);
      chk("rst_avm_write", avm_write, 0);
      chk("rst_pending", dut.pending, 0);
      chk("rst_err", err_underflow, 0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      @(negedge clk_clk);

      // reader only, 4x burst-8
      for (int k = 0; k < 4; k++) begin
         m0_read = 1'b1; m0_burstcount = 7'd8; m0_address = 29'(k * 8);
         #1 chk("p1_idle_wait", m0_waitrequest, 1);
         @(negedge clk_clk); #1;
         chk("p1_avm_read", avm_read, 1);
         chk("p1_m0_wait", m0_waitrequest, 0);
         chk("p1_addr", avm_address, k * 8);
         chk("p1_bc", avm_burstcount, 8);
         @(negedge clk_clk); #1;
         chk("p1_pending", dut.pending, (k + 1) * 8);
      end
      m0_burstcount = 7'd1;
      repeat (2) begin
         @(negedge clk_clk); #1;
         chk("p1_full_wait", m0_waitrequest, 1);
         chk("p1_full_read", avm_read, 0);
         chk("p1_full_pend", dut.pending, 32);
      end
      m0_read = 1'b0;
      avm_readdatavalid = 1'b1;
      avm_readdata = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      #1;
      chk("p1_rdv_pass", m0_readdatavalid, 1);
      chk("p1_rdata_pass", m0_readdata, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
      repeat (16) @(posedge clk_clk);
      #1 chk("p1_pend_half", dut.pending, 16);
      repeat (16) @(posedge clk_clk);
      #1 avm_readdatavalid = 1'b0;
      chk("p1_pend_zero", dut.pending, 0);
      @(negedge clk_clk);

      // credit limit: pending 28, burst 8 waits until pending 24
      rd_cmd(8); rd_cmd(8); rd_cmd(8); rd_cmd(4);
      #1 chk("p2_pend28", dut.pending, 28);
      m0_read = 1'b1; m0_burstcount = 7'd8; avm_readdatavalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("p2_credit_wait", m0_waitrequest, 1);
         @(negedge clk_clk);
      end
      avm_readdatavalid = 1'b0;
      #1;
      chk("p2_pend24", dut.pending, 24);
      chk("p2_still_wait", m0_waitrequest, 1);
      @(negedge clk_clk); #1;
      chk("p2_granted", m0_waitrequest, 0);
      chk("p2_pend_hold", dut.pending, 24);
      @(negedge clk_clk);
      m0_read = 1'b0;
      #1 chk("p2_pend32", dut.pending, 32);
      avm_readdatavalid = 1'b1;
      repeat (32) @(posedge clk_clk);
      #1 avm_readdatavalid = 1'b0;
      chk("p2_pend_zero", dut.pending, 0);
      @(negedge clk_clk);

      // both request continuously, starvation forces the write
      m0_read = 1'b1; m0_burstcount = 7'd4;
      m1_write = 1'b1; m1_burstcount = 7'd4; m1_address = 29'h100;
      m1_writedata = '0;
      #1 chk("p3_s0_m1wait", m1_waitrequest, 1);
      @(negedge clk_clk); #1;
      chk("p3_s1_rdgrant", m0_waitrequest, 0);
      chk("p3_s1_m1wait", m1_waitrequest, 1);
      @(negedge clk_clk);
      @(negedge clk_clk);
      @(negedge clk_clk); #1;
      chk("p3_starve_sat", dut.starve, 4);
      chk("p3_s4_m1wait", m1_waitrequest, 1);
      beats = 0;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk_clk);
         m1_writedata = 128'(b + 1);
         #1;
         chk("p3_wr_grant", m1_waitrequest, 0);
         chk("p3_rd_blocked", m0_waitrequest, 1);
         chk("p3_wdata", avm_writedata, b + 1);
         if (b == 0) begin
            chk("p3_starve_clr", dut.starve, 0);
            chk("p3_waddr", avm_address, 29'h100);
         end
         if (avm_write && !avm_waitrequest) beats++;
      end
      @(negedge clk_clk);
      m1_write = 1'b0;
      #1;
      chk("p3_beats", beats, 4);
      chk("p3_bl_zero", dut.beats_left, 0);
      chk("p3_idle_m0", m0_waitrequest, 1);
      chk("p3_pend8", dut.pending, 8);
      @(negedge clk_clk); #1;
      chk("p3_rd_after", m0_waitrequest, 0);
      @(negedge clk_clk);
      m0_read = 1'b0;
      #1 chk("p3_pend12", dut.pending, 12);
      avm_readdatavalid = 1'b1;
      repeat (12) @(posedge clk_clk);
      #1 avm_readdatavalid = 1'b0;
      chk("p3_pend_zero", dut.pending, 0);
      @(negedge clk_clk);

      // write burst-4 with slave stall on beat 2
      m1_write = 1'b1; m1_burstcount = 7'd4; m1_address = 29'h200;
      beats = 0;
      #1 chk("p4_w0_wait", m1_waitrequest, 1);
      @(negedge clk_clk); #1;
      chk("p4_w1_grant", m1_waitrequest, 0);
      if (avm_write && !avm_waitrequest) beats++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_clk);
         avm_waitrequest = 1'b1;
         #1;
         chk("p4_bl_hold", dut.beats_left, 3);
         chk("p4_stall", m1_waitrequest, 1);
         chk("p4_wr_kept", avm_write, 1);
         if (avm_write && !avm_waitrequest) beats++;
      end
      @(negedge clk_clk);
      avm_waitrequest = 1'b0;
      #1 if (avm_write && !avm_waitrequest) beats++;
      @(negedge clk_clk); #1;
      chk("p4_bl2", dut.beats_left, 2);
      if (avm_write && !avm_waitrequest) beats++;
      @(negedge clk_clk); #1;
      chk("p4_bl1", dut.beats_left, 1);
      if (avm_write && !avm_waitrequest) beats++;
      @(negedge clk_clk);
      m1_write = 1'b0;
      #1;
      chk("p4_beats", beats, 4);
      chk("p4_bl0", dut.beats_left, 0);
      chk("p4_released", m1_waitrequest, 1);
      @(negedge clk_clk);

      // underflow
      avm_readdatavalid = 1'b1;
      #1 chk("p5_err_pre", err_underflow, 0);
      @(negedge clk_clk);
      avm_readdatavalid = 1'b0;
      #1;
      chk("p5_err_set", err_underflow, 1);
      chk("p5_pend_zero", dut.pending, 0);
      @(negedge clk_clk); #1;
      chk("p5_err_sticky", err_underflow, 1);
      @(negedge clk_clk);

      // asynchronous reset in the middle of a write burst
      rd_cmd(4);
      #1 chk("p6_pend4", dut.pending, 4);
      m1_write = 1'b1; m1_burstcount = 7'd4;
      @(negedge clk_clk);
      @(negedge clk_clk); #1;
      chk("p6_bl3", dut.beats_left, 3);
      #2 reset_reset_n = 1'b0;
      #1;
      chk("p6_rst_m1wait", m1_waitrequest, 1);
      chk("p6_rst_write", avm_write, 0);
      chk("p6_rst_bl", dut.beats_left, 0);
      chk("p6_rst_pend", dut.pending, 0);
      chk("p6_rst_err", err_underflow, 0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      m1_write = 1'b0;
      @(negedge clk_clk); #1;
      chk("p6_idle_m0", m0_waitrequest, 1);
      chk("p6_idle_m1", m1_waitrequest, 1);
      chk("p6_pend_zero", dut.pending, 0);
      chk("p6_starve_zero", dut.starve, 0);
      @(negedge clk_clk);
      rd_cmd(2);
      #1 chk("p6_pend2", dut.pending, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
